// File: rtl/booth_mul_arbiter_if.sv
// Requester/response bundle between client blocks and booth_mul_arbiter.
// The slave modport is the arbiter side; master is the client side.
interface booth_mul_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 10,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_p;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sequencer sharing one Booth multiplier among N requesters.
// One operation in flight; product returned tagged with the requester ID.
module booth_mul_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 10,
  parameter int unsigned MUL_LAT = 0,
  parameter int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_mul_arbiter_if.slave   bus,
  output logic [W-1:0]         o_mul_a,
  output logic [W-1:0]         o_mul_b,
  input  logic [2*W-1:0]       i_mul_p,
  output logic                 o_busy,
  output logic [15:0]          o_op_count
);

  localparam int unsigned CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]   r_mul_a, w_mul_a_nxt;
  logic [W-1:0]   r_mul_b, w_mul_b_nxt;
  logic [IDW-1:0] r_rsp_id, w_rsp_id_nxt;
  logic [2*W-1:0] r_rsp_p, w_rsp_p_nxt;
  logic [15:0]    r_op_count, w_op_count_nxt;
  logic           r_rsp_valid, r_busy;
  logic [N-1:0]   w_req_ready_c;
  logic           w_found;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_idx;
  logic [W-1:0]   w_req_a [N];
  logic [W-1:0]   w_req_b [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_req_a[gi] = bus.req_a[gi*W +: W];
    assign w_req_b[gi] = bus.req_b[gi*W +: W];
  end

  // First valid requester scanning from r_ptr with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % N);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_mul_a_nxt    = r_mul_a;
    w_mul_b_nxt    = r_mul_b;
    w_rsp_id_nxt   = r_rsp_id;
    w_rsp_p_nxt    = r_rsp_p;
    w_op_count_nxt = r_op_count;
    w_req_ready_c  = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_req_ready_c[w_gnt] = 1'b1;
          w_mul_a_nxt  = w_req_a[w_gnt];
          w_mul_b_nxt  = w_req_b[w_gnt];
          w_rsp_id_nxt = w_gnt;
          w_ptr_nxt    = IDW'((32'(w_gnt) + 32'd1) % N);
          w_cnt_nxt    = CW'(MUL_LAT);
          w_state_nxt  = CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_rsp_p_nxt = i_mul_p;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_op_count_nxt = r_op_count + 16'd1;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // rsp_valid and busy are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
      r_op_count  <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_p     <= w_rsp_p_nxt;
      r_op_count  <= w_op_count_nxt;
      r_rsp_valid <= (w_state_nxt == RESP);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign bus.req_ready = w_req_ready_c;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_p     = r_rsp_p;
  assign o_mul_a       = r_mul_a;
  assign o_mul_b       = r_mul_b;
  assign o_busy        = r_busy;
  assign o_op_count    = r_op_count;

endmodule
